// File: rtl/counter4b_checker.sv
// Receive-side monitor for a 4-bit ripple-carry counter: locks onto the +1 mod 16
// sequence, extends it to a wider count, and flags and counts sequence/carry violations.
module counter4b_checker #(
    parameter int HI_W     = 12,
    parameter int SYNC_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                Qa,
    input  logic                Qb,
    input  logic                Qc,
    input  logic                Qd,
    input  logic                Rc,
    input  logic                en,
    input  logic                clr_err,
    output logic [HI_W+3:0]     count,
    output logic                locked,
    output logic                wrap_pulse,
    output logic                err_pulse,
    output logic [ERR_W-1:0]    err_cnt
);

    localparam int CNT_W = HI_W + 4;
    // The sample that reaches this match value is the one that completes lock.
    localparam logic [3:0] LOCK_AT = 4'(SYNC_CNT - 1);

    typedef enum logic [0:0] {HUNT = 1'b0, TRACK = 1'b1} state_t;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        if (v == {ERR_W{1'b1}}) begin
            return v;
        end else begin
            return v + ERR_W'(1);
        end
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         prev_q, prev_d;
    logic               prev_valid_q, prev_valid_d;
    logic [3:0]         match_q, match_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

    logic [3:0]         nib_s;
    logic               seq_ok_s;
    logic               rc_ok_s;
    logic               good_s;

    assign nib_s    = {Qd, Qc, Qb, Qa};
    assign seq_ok_s = prev_valid_q && (nib_s == (prev_q + 4'd1));
    assign rc_ok_s  = (Rc == (nib_s == 4'hF));
    assign good_s   = seq_ok_s && rc_ok_s;

    // Next-state: lock acquisition, tracking, violation handling and error counting.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        match_d      = match_q;
        count_d      = count_q;
        wrap_d       = 1'b0;
        err_d        = 1'b0;
        err_cnt_d    = err_cnt_q;
        if (en) begin
            prev_d       = nib_s;
            prev_valid_d = 1'b1;
            case (state_q)
                HUNT: begin
                    if (good_s) begin
                        if (match_q == LOCK_AT) begin
                            state_d = TRACK;
                            count_d = {{HI_W{1'b0}}, nib_s};
                            match_d = 4'd0;
                        end else begin
                            match_d = match_q + 4'd1;
                        end
                    end else begin
                        match_d = 4'd0;
                    end
                end
                TRACK: begin
                    if (good_s) begin
                        count_d = count_q + CNT_W'(1);
                        wrap_d  = (nib_s == 4'd0);
                    end else begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                        match_d = 4'd0;
                    end
                end
                default: begin
                    state_d = HUNT;
                    match_d = 4'd0;
                end
            endcase
            // A same-edge error outranks the clear request.
            if (err_d) begin
                err_cnt_d = clr_err ? ERR_W'(1) : sat_inc(err_cnt_q);
            end else if (clr_err) begin
                err_cnt_d = '0;
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            prev_q       <= 4'd0;
            prev_valid_q <= 1'b0;
            match_q      <= 4'd0;
            count_q      <= '0;
            wrap_q       <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            match_q      <= match_d;
            count_q      <= count_d;
            wrap_q       <= wrap_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign count      = count_q;
    assign locked     = (state_q == TRACK);
    assign wrap_pulse = wrap_q;
    assign err_pulse  = err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_counter4b_checker.sv
// Bench for counter4b_checker: directed scenarios plus randomized traffic, compared
// every cycle against an integer-arithmetic reference model.
module tb_counter4b_checker;

    localparam int HI_W     = 12;
    localparam int SYNC_CNT = 2;
    localparam int CNT_MOD  = 1 << (HI_W + 4);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  nib = 4'd0;
    logic        rc = 1'b0;
    logic        en = 1'b0;
    logic        clr_err = 1'b0;

    logic [HI_W+3:0] count, count2;
    logic            locked, locked2, wrap_pulse, wrap2, err_pulse, err2;
    logic [7:0]      err_cnt;
    logic [1:0]      err_cnt2;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (plain integers)
    int m_prev, m_match, m_count, m_err8, m_err2;
    bit m_pv, m_lock, m_wrap, m_errp;

    counter4b_checker #(.HI_W(HI_W), .SYNC_CNT(SYNC_CNT), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .Qa(nib[0]), .Qb(nib[1]), .Qc(nib[2]), .Qd(nib[3]),
        .Rc(rc), .en(en), .clr_err(clr_err), .count(count), .locked(locked),
        .wrap_pulse(wrap_pulse), .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    counter4b_checker #(.HI_W(HI_W), .SYNC_CNT(SYNC_CNT), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .Qa(nib[0]), .Qb(nib[1]), .Qc(nib[2]), .Qd(nib[3]),
        .Rc(rc), .en(en), .clr_err(clr_err), .count(count2), .locked(locked2),
        .wrap_pulse(wrap2), .err_pulse(err2), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour for one clock edge.
    task automatic model_edge();
        bit good;
        if (!rst_n) begin
            m_prev = 0; m_pv = 0; m_match = 0; m_lock = 0; m_count = 0;
            m_err8 = 0; m_err2 = 0; m_wrap = 0; m_errp = 0;
        end else begin
            m_wrap = 0;
            m_errp = 0;
            if (en) begin
                good = m_pv && (int'(nib) == (m_prev + 1) % 16) && (rc == (nib == 4'd15));
                if (!m_lock) begin
                    if (good) begin
                        m_match++;
                        if (m_match >= SYNC_CNT) begin
                            m_lock = 1; m_count = int'(nib); m_match = 0;
                        end
                    end else begin
                        m_match = 0;
                    end
                end else if (good) begin
                    m_count = (m_count + 1) % CNT_MOD;
                    m_wrap = (nib == 4'd0);
                end else begin
                    m_errp = 1; m_lock = 0; m_match = 0;
                end
                if (m_errp) begin
                    m_err8 = clr_err ? 1 : (m_err8 < 255 ? m_err8 + 1 : 255);
                    m_err2 = clr_err ? 1 : (m_err2 < 3 ? m_err2 + 1 : 3);
                end else if (clr_err) begin
                    m_err8 = 0; m_err2 = 0;
                end
                m_prev = int'(nib);
                m_pv = 1;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic [3:0] n,
                       input logic c, input logic clr);
        rst_n = r; en = e; nib = n; rc = c; clr_err = clr;
        @(posedge clk);
        model_edge();
        #1;
        check("count",      32'(count),      32'(m_count));
        check("locked",     32'(locked),     32'(m_lock));
        check("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
        check("err_pulse",  32'(err_pulse),  32'(m_errp));
        check("err_cnt",    32'(err_cnt),    32'(m_err8));
        check("err_cnt_w2", 32'(err_cnt2),   32'(m_err2));
        check("locked_w2",  32'(locked2),    32'(m_lock));
    endtask

    task automatic cg(input int v);
        cyc(1'b1, 1'b1, 4'(v), (v % 16) == 15, 1'b0);
    endtask

    initial begin
        int gen;
        int p;
        logic [3:0] rn;
        // Reset
        cyc(1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        // Free-running count 0..39
        for (int i = 0; i < 40; i++) begin
            cg(i % 16);
            if (i == 2) begin
                check("lock_count", 32'(count), 32'd2);
                check("lock_flag", 32'(locked), 32'd1);
            end
            if (i == 16) check("wrap_count", 32'(count), 32'd16);
        end
        check("no_err_40", 32'(err_cnt), 32'd0);
        // Sequence fault 5 -> 7, then relock on 8,9,10
        for (int v = 8; v <= 21; v++) cg(v % 16);
        cyc(1'b1, 1'b1, 4'd7, 1'b0, 1'b0);
        check("seq_err_cnt", 32'(err_cnt), 32'd1);
        check("seq_unlock", 32'(locked), 32'd0);
        cg(8); cg(9); cg(10);
        check("relock_count", 32'(count), 32'd10);
        // Carry faults
        for (int v = 11; v <= 14; v++) cg(v);
        cyc(1'b1, 1'b1, 4'd15, 1'b0, 1'b0);
        cg(0); cg(1); cg(2);
        cyc(1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        check("rc_err_cnt", 32'(err_cnt), 32'd3);
        // Enable gap while frozen
        cg(4); cg(5); cg(6);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 4'd6, 1'b0, 1'b0);
        cg(7); cg(8);
        check("en_gap_lock", 32'(locked), 32'd1);
        // Repeated errors: saturation and clear-vs-error priority
        gen = 8;
        for (int k = 0; k < 5; k++) begin
            cg(gen + 1); cg(gen + 2); cg(gen + 3);
            gen = (gen + 3) % 16;
            cyc(1'b1, 1'b1, 4'(gen), gen == 15, 1'b0);
        end
        check("sat_w2", 32'(err_cnt2), 32'd3);
        cg(gen + 1); cg(gen + 2); cg(gen + 3);
        gen = (gen + 3) % 16;
        cyc(1'b1, 1'b1, 4'(gen), gen == 15, 1'b1);
        check("clr_vs_err", 32'(err_cnt), 32'd1);
        // Reset while locked
        for (int k = 1; k <= 5; k++) cg(gen + k);
        gen = (gen + 5) % 16;
        cyc(1'b0, 1'b1, 4'(gen + 1), 1'b0, 1'b0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_err", 32'(err_cnt), 32'd0);
        gen = 0;
        cg(0); cg(1); cg(2);
        check("post_rst_lock", 32'(locked), 32'd1);
        // Randomized traffic
        gen = 2;
        for (int k = 0; k < 3000; k++) begin
            p = int'($urandom_range(0, 99));
            rn = 4'($urandom_range(0, 15));
            if (p < 78) begin
                gen = (gen + 1) % 16;
                cyc(1'b1, 1'b1, 4'(gen), gen == 15, $urandom_range(0, 19) == 0);
            end else if (p < 85) begin
                gen = int'(rn);
                cyc(1'b1, 1'b1, rn, rn == 4'd15, $urandom_range(0, 19) == 0);
            end else if (p < 89) begin
                gen = (gen + 1) % 16;
                cyc(1'b1, 1'b1, 4'(gen), gen != 15, $urandom_range(0, 3) == 0);
            end else if (p < 98) begin
                cyc(1'b1, 1'b0, rn, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                cyc(1'b0, 1'($urandom_range(0, 1)), rn, 1'b0, 1'b0);
            end
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
